// File: rtl/dcache_bridge_pkg.sv
// dcache_bridge_pkg: request encodings, AXI constants and FSM states
// shared by the dcache to AXI4 bridge.
package dcache_bridge_pkg;

  localparam logic [2:0] REQ_BYTE = 3'b000;
  localparam logic [2:0] REQ_HALF = 3'b001;
  localparam logic [2:0] REQ_WORD = 3'b010;
  localparam logic [2:0] REQ_LINE = 3'b100;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  localparam logic [2:0] AXI_SIZE_1B = 3'd0;
  localparam logic [2:0] AXI_SIZE_2B = 3'd1;
  localparam logic [2:0] AXI_SIZE_4B = 3'd2;

  localparam int BEAT_W = 2;

  typedef enum logic [1:0] {
    R_IDLE,
    R_AR,
    R_DATA
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_XFER,
    W_RESP
  } wr_state_t;

  // Line requests start on the line boundary
  function automatic logic [31:0] axi_addr(
    input logic [31:0] a,
    input logic [2:0]  t
  );
    axi_addr = (t == REQ_LINE) ? {a[31:4], 4'b0} : a;
  endfunction

  function automatic logic [2:0] axi_size(
    input logic [2:0] t
  );
    axi_size = (t == REQ_LINE) ? AXI_SIZE_4B : {1'b0, t[1:0]};
  endfunction

endpackage

// File: rtl/axi_wline_buffer.sv
// axi_wline_buffer: holds a cache line for a write burst and
// steps through its words as W beats are accepted.
module axi_wline_buffer
  import dcache_bridge_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load,
  input  logic [32*WORDS-1:0]   i_data,
  input  logic                  i_beat,
  output logic [31:0]           o_wdata,
  output logic                  o_last
);

  localparam logic [BEAT_W-1:0] LAST = BEAT_W'(WORDS - 1);

  logic [31:0]       r_word [WORDS];
  logic [BEAT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
      for (int i = 0; i < WORDS; i++) begin
        r_word[i] <= '0;
      end
    end else if (i_load) begin
      r_cnt <= '0;
      for (int i = 0; i < WORDS; i++) begin
        r_word[i] <= i_data[32*i +: 32];
      end
    end else if (i_beat && (r_cnt != LAST)) begin
      // Saturate so a stray beat never wraps to word 0
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_wdata = r_word[r_cnt];
  assign o_last  = (r_cnt == LAST);

endmodule

// File: rtl/dcache_axi_bridge.sv
// dcache_axi_bridge: dcache miss/writeback port to one AXI4 master.
// Define DCACHE_BRIDGE_RAW_CHECK_EN to hold reads hitting a pending write line.
module dcache_axi_bridge
  import dcache_bridge_pkg::*;
#(
  parameter logic [3:0] AXI_ID     = 4'd0,
  parameter int         LINE_WORDS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rd_req,
  input  logic [2:0]              rd_type,
  input  logic [31:0]             rd_addr,
  output logic                    rd_rdy,
  output logic                    ret_valid,
  output logic                    ret_last,
  output logic [31:0]             ret_data,
  input  logic                    wr_req,
  input  logic [2:0]              wr_type,
  input  logic [31:0]             wr_addr,
  input  logic [3:0]              wr_wstrb,
  input  logic [32*LINE_WORDS-1:0] wr_data,
  output logic                    wr_rdy,
  output logic [3:0]              arid,
  output logic [31:0]             araddr,
  output logic [7:0]              arlen,
  output logic [2:0]              arsize,
  output logic [1:0]              arburst,
  output logic                    arvalid,
  input  logic                    arready,
  input  logic [3:0]              rid,
  input  logic [31:0]             rdata,
  input  logic [1:0]              rresp,
  input  logic                    rlast,
  input  logic                    rvalid,
  output logic                    rready,
  output logic [3:0]              awid,
  output logic [31:0]             awaddr,
  output logic [7:0]              awlen,
  output logic [2:0]              awsize,
  output logic [1:0]              awburst,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [31:0]             wdata,
  output logic [3:0]              wstrb,
  output logic                    wlast,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic [3:0]              bid,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready
);

  localparam logic [7:0] LINE_LEN = 8'(LINE_WORDS - 1);

  logic        r_live;
  rd_state_t   r_rd_state;
  rd_state_t   w_rd_next;
  logic [31:0] r_rd_addr;
  logic [2:0]  r_rd_type;
  logic        w_rd_acc;
  logic        w_rd_line;
  logic        w_raw_hit;

  wr_state_t   r_wr_state;
  wr_state_t   w_wr_next;
  logic [31:0] r_wr_addr;
  logic [2:0]  r_wr_type;
  logic [3:0]  r_wr_strb;
  logic        r_aw_done;
  logic        r_w_done;
  logic        w_wr_acc;
  logic        w_wr_line;
  logic        w_xfer;
  logic        w_aw_fire;
  logic        w_w_fire;
  logic        w_wl_fire;
  logic [31:0] w_buf_wdata;
  logic        w_buf_last;
  logic        w_unused;

  assign w_unused = ^{rid, rresp, bid, bresp};

  // Ready outputs stay low through reset and rise one cycle later
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_live <= 1'b0;
    end else begin
      r_live <= 1'b1;
    end
  end

  assign w_wr_acc = wr_req && wr_rdy;
  assign w_rd_acc = rd_req && rd_rdy;

`ifdef DCACHE_BRIDGE_RAW_CHECK_EN
  assign w_raw_hit =
    ((r_wr_state != W_IDLE) &&
     (rd_addr[31:4] == r_wr_addr[31:4])) ||
    (w_wr_acc &&
     (rd_addr[31:4] == wr_addr[31:4]));
`else
  assign w_raw_hit = 1'b0;
`endif

  assign rd_rdy = r_live &&
                  (r_rd_state == R_IDLE) &&
                  !w_raw_hit;
  assign wr_rdy = r_live &&
                  (r_wr_state == W_IDLE);

  always_comb begin
    w_rd_next = r_rd_state;
    unique case (r_rd_state)
      R_IDLE: if (w_rd_acc) w_rd_next = R_AR;
      R_AR:   if (arready)  w_rd_next = R_DATA;
      R_DATA: if (rvalid && rlast) w_rd_next = R_IDLE;
      default: w_rd_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_state <= R_IDLE;
      r_rd_addr  <= '0;
      r_rd_type  <= '0;
      ret_valid  <= 1'b0;
      ret_last   <= 1'b0;
      ret_data   <= '0;
    end else begin
      r_rd_state <= w_rd_next;
      if (w_rd_acc) begin
        r_rd_addr <= rd_addr;
        r_rd_type <= rd_type;
      end
      ret_valid <= (r_rd_state == R_DATA) && rvalid;
      if ((r_rd_state == R_DATA) && rvalid) begin
        ret_data <= rdata;
        ret_last <= rlast;
      end else begin
        ret_last <= 1'b0;
      end
    end
  end

  assign w_rd_line = (r_rd_type == REQ_LINE);
  assign arid      = r_live ? AXI_ID : 4'd0;
  assign araddr    = axi_addr(r_rd_addr, r_rd_type);
  assign arlen     = w_rd_line ? LINE_LEN : 8'd0;
  assign arsize    = axi_size(r_rd_type);
  assign arburst   = r_live ? AXI_BURST_INCR : 2'b00;
  assign arvalid   = (r_rd_state == R_AR);
  assign rready    = (r_rd_state == R_DATA);

  assign w_xfer    = (r_wr_state == W_XFER);
  assign awvalid   = w_xfer && !r_aw_done;
  assign wvalid    = w_xfer && !r_w_done;
  assign w_aw_fire = awvalid && awready;
  assign w_w_fire  = wvalid && wready;
  assign w_wl_fire = w_w_fire && wlast;

  always_comb begin
    w_wr_next = r_wr_state;
    unique case (r_wr_state)
      W_IDLE: if (w_wr_acc) w_wr_next = W_XFER;
      W_XFER: begin
        // AW and the last W beat may land in either order
        if ((r_aw_done || w_aw_fire) &&
            (r_w_done || w_wl_fire)) begin
          w_wr_next = W_RESP;
        end
      end
      W_RESP: if (bvalid) w_wr_next = W_IDLE;
      default: w_wr_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_state <= W_IDLE;
      r_wr_addr  <= '0;
      r_wr_type  <= '0;
      r_wr_strb  <= '0;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
    end else begin
      r_wr_state <= w_wr_next;
      if (w_wr_acc) begin
        r_wr_addr <= wr_addr;
        r_wr_type <= wr_type;
        r_wr_strb <= wr_wstrb;
      end
      if (w_xfer && (w_wr_next == W_XFER)) begin
        if (w_aw_fire) r_aw_done <= 1'b1;
        if (w_wl_fire) r_w_done  <= 1'b1;
      end else begin
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end
    end
  end

  axi_wline_buffer #(
    .WORDS (LINE_WORDS)
  ) u_wbuf (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_wr_acc),
    .i_data  (wr_data),
    .i_beat  (w_w_fire),
    .o_wdata (w_buf_wdata),
    .o_last  (w_buf_last)
  );

  assign w_wr_line = (r_wr_type == REQ_LINE);
  assign awid      = r_live ? AXI_ID : 4'd0;
  assign awaddr    = axi_addr(r_wr_addr, r_wr_type);
  assign awlen     = w_wr_line ? LINE_LEN : 8'd0;
  assign awsize    = axi_size(r_wr_type);
  assign awburst   = r_live ? AXI_BURST_INCR : 2'b00;
  assign wdata     = w_buf_wdata;
  assign wstrb     = w_wr_line ? 4'hF : r_wr_strb;
  assign wlast     = w_xfer && (w_wr_line ? w_buf_last : 1'b1);
  assign bready    = (r_wr_state == W_RESP);

endmodule

// File: tb/tb_dcache_axi_bridge.sv
// tb_dcache_axi_bridge: directed stimulus with an AXI slave model
// and a queue scoreboard checked by a separate monitor.
module tb_dcache_axi_bridge;
  import dcache_bridge_pkg::*;

`ifdef DCACHE_BRIDGE_RAW_CHECK_EN
  localparam logic RAW_ON = 1'b1;
`else
  localparam logic RAW_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         rd_req;
  logic [2:0]   rd_type;
  logic [31:0]  rd_addr;
  logic         rd_rdy;
  logic         ret_valid;
  logic         ret_last;
  logic [31:0]  ret_data;
  logic         wr_req;
  logic [2:0]   wr_type;
  logic [31:0]  wr_addr;
  logic [3:0]   wr_wstrb;
  logic [127:0] wr_data;
  logic         wr_rdy;
  logic [3:0]   arid;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         arvalid;
  logic         arready;
  logic [3:0]   rid;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rlast;
  logic         rvalid;
  logic         rready;
  logic [3:0]   awid;
  logic [31:0]  awaddr;
  logic [7:0]   awlen;
  logic [2:0]   awsize;
  logic [1:0]   awburst;
  logic         awvalid;
  logic         awready;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         wlast;
  logic         wvalid;
  logic         wready;
  logic [3:0]   bid;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready;

  always #5 clk = ~clk;

  dcache_axi_bridge dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr),
    .rd_rdy(rd_rdy), .ret_valid(ret_valid), .ret_last(ret_last),
    .ret_data(ret_data),
    .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr),
    .wr_wstrb(wr_wstrb), .wr_data(wr_data), .wr_rdy(wr_rdy),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
    .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
  } ax_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } w_t;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } ret_t;

  ax_t         exp_ar [$];
  ax_t         exp_aw [$];
  w_t          exp_w  [$];
  ret_t        exp_ret[$];
  logic [31:0] rdata_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int ar_cyc = -1;
  int aw_cyc = -1;
  int b_cyc = -1;
  int ret_seen = 0;
  int ar_lat = 0;
  logic b_hold = 1'b0;

  logic [255:0] all_out;
  assign all_out = 256'({rd_rdy, ret_valid, ret_last, ret_data,
    wr_rdy, arid, araddr, arlen, arsize, arburst, arvalid, rready,
    awid, awaddr, awlen, awsize, awburst, awvalid,
    wdata, wstrb, wlast, wvalid, bready});

  task automatic chk(input string nm,
                     input logic [255:0] act,
                     input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic miss(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got a handshake expected none", nm);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Scoreboard monitor: inputs settle before the falling edge
  initial forever begin
    ax_t  a;
    w_t   w;
    ret_t r;
    @(negedge clk);
    if (rst) begin
      if (arvalid && arready) begin
        ar_cyc = cyc;
        if (exp_ar.size() == 0) miss("ar");
        else begin
          a = exp_ar.pop_front();
          chk("ar", 256'({araddr, arlen, arsize, arburst, arid}),
                    256'({a.addr, a.len, a.size, 2'b01, 4'd0}));
        end
      end
      if (awvalid && awready) begin
        aw_cyc = cyc;
        if (exp_aw.size() == 0) miss("aw");
        else begin
          a = exp_aw.pop_front();
          chk("aw", 256'({awaddr, awlen, awsize, awburst, awid}),
                    256'({a.addr, a.len, a.size, 2'b01, 4'd0}));
        end
      end
      if (wvalid && wready) begin
        if (exp_w.size() == 0) miss("w");
        else begin
          w = exp_w.pop_front();
          chk("w", 256'({wdata, wstrb, wlast}), 256'(w));
        end
      end
      if (bvalid && bready) b_cyc = cyc;
      if (ret_valid) begin
        ret_seen++;
        if (exp_ret.size() == 0) miss("ret");
        else begin
          r = exp_ret.pop_front();
          chk("ret", 256'({ret_data, ret_last}), 256'(r));
        end
      end
    end
  end

  // AXI read slave
  initial begin
    logic ar_hs;
    logic r_hs;
    logic [7:0] ar_len;
    int beats;
    int lat;
    arready = 0; rvalid = 0; rlast = 0;
    rdata = 0; rid = 0; rresp = 0;
    beats = 0; lat = 0;
    forever begin
      @(negedge clk);
      ar_hs  = arvalid && arready;
      r_hs   = rvalid && rready;
      ar_len = arlen;
      @(posedge clk); #1;
      if (!rst) begin
        arready = 0; rvalid = 0; rlast = 0;
        beats = 0; lat = 0;
        rdata_q.delete();
      end else begin
        if (r_hs) begin
          rvalid = 0; rlast = 0;
        end
        if (ar_hs) begin
          arready = 0;
          lat = 0;
          beats = int'(ar_len) + 1;
        end else if (arvalid) begin
          if (lat >= ar_lat) arready = 1;
          else lat++;
        end
        if (!rvalid && beats > 0) begin
          rvalid = 1;
          rdata = (rdata_q.size() > 0) ? rdata_q.pop_front()
                                       : 32'hBAD0_BAD0;
          rlast = (beats == 1);
          rresp = 2'b00;
          beats--;
        end
      end
    end
  end

  // AXI write slave: wready toggles while wvalid is high
  initial begin
    logic aw_hs;
    logic wl_hs;
    logic b_hs;
    logic aw_got;
    logic w_got;
    awready = 0; wready = 0; bvalid = 0;
    bid = 0; bresp = 0;
    aw_got = 0; w_got = 0;
    forever begin
      @(negedge clk);
      aw_hs = awvalid && awready;
      wl_hs = wvalid && wready && wlast;
      b_hs  = bvalid && bready;
      @(posedge clk); #1;
      if (!rst) begin
        awready = 0; wready = 0; bvalid = 0;
        aw_got = 0; w_got = 0;
      end else begin
        if (aw_hs) aw_got = 1;
        if (wl_hs) w_got = 1;
        if (b_hs) bvalid = 0;
        if (aw_got && w_got && !bvalid && !b_hold) begin
          bvalid = 1;
          aw_got = 0;
          w_got = 0;
        end
        awready = awvalid;
        wready = wvalid ? ~wready : 1'b0;
      end
    end
  end

  task automatic do_read(input logic [31:0] a,
                         input logic [2:0] t,
                         output logic first,
                         output int acc);
    int n = 0;
    logic ok;
    @(posedge clk); #1;
    rd_req = 1; rd_addr = a; rd_type = t;
    @(negedge clk);
    first = rd_rdy;
    ok = rd_rdy;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = rd_rdy;
      n++;
    end
    acc = cyc;
    chk("rd_accept", 256'(ok), 256'(1));
    @(posedge clk); #1;
    rd_req = 0;
  endtask

  task automatic do_write(input logic [31:0] a,
                          input logic [2:0] t,
                          input logic [3:0] s,
                          input logic [127:0] d,
                          output logic first);
    int n = 0;
    logic ok;
    @(posedge clk); #1;
    wr_req = 1; wr_addr = a; wr_type = t;
    wr_wstrb = s; wr_data = d;
    @(negedge clk);
    first = wr_rdy;
    ok = wr_rdy;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = wr_rdy;
      n++;
    end
    chk("wr_accept", 256'(ok), 256'(1));
    @(posedge clk); #1;
    wr_req = 0;
  endtask

  task automatic drain(input string nm);
    int n = 0;
    logic done = 0;
    while (!done && n < 300) begin
      @(negedge clk); #1;
      done = (exp_ar.size() == 0) && (exp_aw.size() == 0) &&
             (exp_w.size() == 0) && (exp_ret.size() == 0) &&
             rd_rdy && wr_rdy && !ret_valid;
      n++;
    end
    chk(nm, 256'(done), 256'(1));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic f1;
    logic f2;
    int acc;
    int n;
    rst = 0;
    rd_req = 0; rd_type = 0; rd_addr = 0;
    wr_req = 0; wr_type = 0; wr_addr = 0;
    wr_wstrb = 0; wr_data = 0;

    repeat (3) @(posedge clk);
    #1 chk("reset_outputs", all_out, 256'(0));
    @(negedge clk);
    rst = 1;
    #1 chk("rdy_after_release", 256'({rd_rdy, wr_rdy}), 256'(0));
    @(posedge clk); #1;
    chk("rdy_rise", 256'({rd_rdy, wr_rdy}), 256'(2'b11));

    // Line read, arready after two cycles
    ar_lat = 2;
    exp_ar.push_back('{32'h1C00_0030, 8'd3, 3'd2});
    for (int i = 1; i <= 4; i++) begin
      rdata_q.push_back(32'(i));
      exp_ret.push_back('{32'(i), i == 4});
    end
    do_read(32'h1C00_0034, REQ_LINE, f1, acc);
    drain("line_read_done");

    // Line write with toggling wready
    exp_aw.push_back('{32'h8000_0010, 8'd3, 3'd2});
    exp_w.push_back('{32'h1111_1111, 4'hF, 1'b0});
    exp_w.push_back('{32'h2222_2222, 4'hF, 1'b0});
    exp_w.push_back('{32'h3333_3333, 4'hF, 1'b0});
    exp_w.push_back('{32'h4444_4444, 4'hF, 1'b1});
    do_write(32'h8000_0010, REQ_LINE, 4'h0,
      128'h4444_4444_3333_3333_2222_2222_1111_1111, f1);
    n = 0;
    while (!(bvalid && bready) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("b_seen", 256'(bvalid && bready), 256'(1));
    chk("wr_rdy_during_b", 256'(wr_rdy), 256'(0));
    @(negedge clk);
    chk("wr_rdy_after_b", 256'(wr_rdy), 256'(1));
    drain("line_write_done");

    // Concurrent line read and line write, different lines
    ar_lat = 0;
    exp_ar.push_back('{32'h2000_0000, 8'd3, 3'd2});
    for (int i = 0; i < 4; i++) begin
      rdata_q.push_back(32'hA0 + 32'(i));
      exp_ret.push_back('{32'hA0 + 32'(i), i == 3});
    end
    exp_aw.push_back('{32'h3000_0020, 8'd3, 3'd2});
    for (int i = 0; i < 4; i++) begin
      exp_w.push_back('{32'hC0 + 32'(i), 4'hF, i == 3});
    end
    fork
      do_read(32'h2000_0004, REQ_LINE, f1, acc);
      do_write(32'h3000_0020, REQ_LINE, 4'h0,
        {32'hC3, 32'hC2, 32'hC1, 32'hC0}, f2);
    join
    chk("both_accepted_first", 256'({f1, f2}), 256'(2'b11));
    drain("concurrent_done");
    chk("ar_aw_same_cycle", 256'(ar_cyc), 256'(aw_cyc));

    // Word write held in W_RESP, then a read to the same line
    b_hold = 1;
    exp_aw.push_back('{32'h0000_0100, 8'd0, 3'd2});
    exp_w.push_back('{32'hDEAD_BEEF, 4'h3, 1'b1});
    do_write(32'h0000_0100, REQ_WORD, 4'h3,
      128'hDEAD_BEEF, f1);
    repeat (6) @(posedge clk);
    exp_ar.push_back('{32'h0000_0108, 8'd0, 3'd2});
    rdata_q.push_back(32'h55AA_55AA);
    exp_ret.push_back('{32'h55AA_55AA, 1'b1});
    fork
      do_read(32'h0000_0108, REQ_WORD, f2, acc);
      begin
        repeat (5) @(negedge clk);
        b_hold = 0;
      end
    join
    chk("raw_first_rd_rdy", 256'(f2), 256'(!RAW_ON));
`ifdef DCACHE_BRIDGE_RAW_CHECK_EN
    chk("raw_accept_after_b", 256'(acc > b_cyc), 256'(1));
`endif
    drain("raw_done");

    // Reset in the middle of a line read after beat 2
    exp_ar.push_back('{32'h1C00_0040, 8'd3, 3'd2});
    for (int i = 0; i < 4; i++) begin
      rdata_q.push_back(32'hD0 + 32'(i));
    end
    exp_ret.push_back('{32'hD0, 1'b0});
    exp_ret.push_back('{32'hD1, 1'b0});
    n = ret_seen + 2;
    do_read(32'h1C00_0040, REQ_LINE, f1, acc);
    acc = 0;
    while (ret_seen < n && acc < 100) begin
      @(negedge clk); #2;
      acc++;
    end
    chk("two_beats_before_reset", 256'(ret_seen), 256'(n));
    rst = 0;
    #1 chk("mid_burst_reset_outputs", all_out, 256'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1;

    // Byte read restarts cleanly
    exp_ar.push_back('{32'h1C00_0035, 8'd0, 3'd0});
    rdata_q.push_back(32'h0000_00EE);
    exp_ret.push_back('{32'h0000_00EE, 1'b1});
    do_read(32'h1C00_0035, REQ_BYTE, f1, acc);
    drain("byte_read_done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
